// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a fixed-latency IDLE/BUSY/DONE handshake.
// Invalid accesses finish on the normal schedule, raise err and never touch memory.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        err,
  output logic [1:0]  o_state
);

  // Handshake: a request is read|write held stable by the initiator while
  // waitrequest is high; the single cycle with waitrequest low (DONE) completes it.

  localparam int          IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U   = DEPTH_WORDS;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req;
  logic        w_live;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_rd;
  logic        w_wr;
  logic [31:0] w_idx;
  logic [IW-1:0] w_mem_idx;
  logic        w_valid;
  logic        w_commit;

  assign w_req  = read | write;
  // With zero wait cycles the commit happens straight from IDLE, so use the live inputs there.
  assign w_live    = (r_state == S_IDLE);
  assign w_addr    = w_live ? address    : r_addr;
  assign w_wdata   = w_live ? writedata  : r_wdata;
  assign w_be      = w_live ? byteenable : r_be;
  assign w_rd      = w_live ? read       : r_rd;
  assign w_wr      = w_live ? write      : r_wr;
  assign w_idx     = (w_addr - BASE_ADDR) >> 2;
  assign w_mem_idx = w_idx[IW-1:0];
  assign w_valid   = (w_addr[1:0] == 2'b00) && (w_addr >= BASE_ADDR) &&
                     (w_idx < DEPTH_U) && !(w_rd && w_wr);

  // BUSY lasts WAIT_CYCLES cycles: the last one is where the counter steps to 0.
  always_comb begin
    w_next      = r_state;
    waitrequest = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        waitrequest = w_req;
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_next   = S_DONE;
            w_commit = 1'b1;
          end else begin
            w_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        waitrequest = 1'b1;
        if (!w_req) begin
          w_next = S_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next   = S_DONE;
          w_commit = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_commit && !w_valid;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= address;
        r_wdata <= writedata;
        r_be    <= byteenable;
        r_rd    <= read;
        r_wr    <= write;
        r_cnt   <= WAIT_INIT;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        if (!w_valid) begin
          r_rdata <= 32'd0;
        end else if (w_rd) begin
          r_rdata <= r_mem[w_mem_idx];
        end
      end
    end
  end

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_commit && w_valid && w_wr && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign readdata = r_rdata;
  assign err      = r_err;
  assign o_state  = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait cycles, one with 0.
// Drivers push expected completions; monitors pop them when a DUT completes a transfer.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] addr_2, wdata_2, rdata_2;
  logic        rd_2, wr_2, wreq_2, err_2;
  logic [3:0]  be_2;
  logic [1:0]  state_2;

  logic [31:0] addr_0, wdata_0, rdata_0;
  logic        rd_0, wr_0, wreq_0, err_0;
  logic [3:0]  be_0;
  logic [1:0]  state_0;

  data_mem_responder #(.WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .address(addr_2), .read(rd_2), .write(wr_2),
    .writedata(wdata_2), .byteenable(be_2), .readdata(rdata_2),
    .waitrequest(wreq_2), .err(err_2), .o_state(state_2)
  );

  data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(addr_0), .read(rd_0), .write(wr_0),
    .writedata(wdata_0), .byteenable(be_0), .readdata(rdata_0),
    .waitrequest(wreq_0), .err(err_0), .o_state(state_0)
  );

  int n_pass  = 0;
  int n_total = 0;
  // Entry layout: {check_rdata, exp_err, exp_rdata}
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic score(input string who, input logic [31:0] rdata, input logic e);
    logic [33:0] x;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s_unexpected_completion: got rdata %h err %0d expected none", who, rdata, e);
    end else begin
      x = exp_q.pop_front();
      check({who, "_err"}, {31'd0, e}, {31'd0, x[32]});
      if (x[33]) check({who, "_rdata"}, rdata, x[31:0]);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset && (rd_2 | wr_2) && !wreq_2) score("dut2", rdata_2, err_2);
    if (!reset && (rd_0 | wr_0) && !wreq_0) score("dut0", rdata_0, err_0);
  end

  task automatic idle();
    rd_2 = 0; wr_2 = 0; addr_2 = '0; wdata_2 = '0; be_2 = '0;
    rd_0 = 0; wr_0 = 0; addr_0 = '0; wdata_0 = '0; be_0 = '0;
  endtask

  // Called at a falling edge; returns at the falling edge after the DONE cycle
  // with the request still driven so the next call can follow back-to-back.
  task automatic do_req(input bit d0, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rd, input bit exp_err, input bit chk,
                        input string name);
    int n;
    exp_q.push_back({chk, exp_err, exp_rd});
    if (d0) begin rd_0 = rd; wr_0 = wr; addr_0 = a; wdata_0 = wd; be_0 = be; end
    else    begin rd_2 = rd; wr_2 = wr; addr_2 = a; wdata_2 = wd; be_2 = be; end
    n = 1;
    #1;
    while ((d0 ? wreq_0 : wreq_2) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, d0 ? 32'd2 : 32'd4);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata_2, 32'd0);
    check("rst_err",   {31'd0, err_2}, 32'd0);
    check("rst_wreq",  {31'd0, wreq_2}, 32'd0);
    check("rst_state", {30'd0, state_2}, 32'd0);
    reset = 1'b0;

    do_req(0, 0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, "st_1000");
    do_req(0, 1, 0, 32'h1000, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1, "ld_1000");
    do_req(0, 0, 1, 32'h1004, 32'h11223344, 4'hF, 32'h0, 0, 0, "st_1004");
    do_req(0, 0, 1, 32'h1004, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0, "st_lanes");
    do_req(0, 1, 0, 32'h1004, 32'h0, 4'hF, 32'h11BB33DD, 0, 1, "ld_lanes");
    do_req(0, 1, 0, 32'h1002, 32'h0, 4'hF, 32'h0, 1, 1, "ld_misalign");
    do_req(0, 0, 1, 32'h1FFC, 32'h600DCAFE, 4'hF, 32'h0, 0, 0, "st_last");
    do_req(0, 0, 1, 32'h0FFC, 32'h12345678, 4'hF, 32'h0, 1, 1, "st_below");
    do_req(0, 1, 0, 32'h1FFC, 32'h0, 4'hF, 32'h600DCAFE, 0, 1, "ld_last");
    do_req(0, 1, 0, 32'h2000, 32'h0, 4'hF, 32'h0, 1, 1, "ld_past_end");
    do_req(0, 1, 1, 32'h1000, 32'h0, 4'hF, 32'h0, 1, 1, "rd_and_wr");
    do_req(0, 0, 1, 32'h1000, 32'h0, 4'h0, 32'h0, 0, 0, "st_be0");
    do_req(0, 1, 0, 32'h1000, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1, "ld_after_err");

    // Abort: drop the write in the first BUSY cycle.
    do_req(0, 0, 1, 32'h1008, 32'h55667788, 4'hF, 32'h0, 0, 0, "st_1008");
    do_req(0, 1, 0, 32'h1008, 32'h0, 4'hF, 32'h55667788, 0, 1, "ld_1008");
    idle();
    wr_2 = 1; addr_2 = 32'h1008; wdata_2 = 32'hFFFFFFFF; be_2 = 4'hF;
    @(negedge clk);
    check("abort_busy_state", {30'd0, state_2}, 32'd1);
    idle();
    @(negedge clk);
    check("abort_idle_state", {30'd0, state_2}, 32'd0);
    check("abort_rdata",      rdata_2, 32'h55667788);
    check("abort_err",        {31'd0, err_2}, 32'd0);
    do_req(0, 1, 0, 32'h1008, 32'h0, 4'hF, 32'h55667788, 0, 1, "ld_after_abort");

    // Reset during BUSY of a store.
    idle();
    wr_2 = 1; addr_2 = 32'h1008; wdata_2 = 32'h0BADF00D; be_2 = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstbusy_state", {30'd0, state_2}, 32'd0);
    check("rstbusy_rdata", rdata_2, 32'd0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    do_req(0, 1, 0, 32'h1008, 32'h0, 4'hF, 32'h55667788, 0, 1, "ld_after_rst");
    idle();

    // Zero-wait instance, including back-to-back reads.
    do_req(1, 0, 1, 32'h1010, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0, "w0_st_1010");
    do_req(1, 0, 1, 32'h1014, 32'h01020304, 4'hF, 32'h0, 0, 0, "w0_st_1014");
    do_req(1, 1, 0, 32'h1010, 32'h0, 4'hF, 32'hCAFEF00D, 0, 1, "w0_ld_1010");
    do_req(1, 1, 0, 32'h1014, 32'h0, 4'hF, 32'h01020304, 0, 1, "w0_ld_1014");
    do_req(1, 1, 0, 32'h2000, 32'h0, 4'hF, 32'h0, 1, 1, "w0_ld_past_end");
    idle();

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, number of BUSY cycles per access.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the ports are named clk and reset.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  32  byte address from the datapath load/store unit.
REQ-008 read  input  1  load request (lw).
REQ-009 write  input  1  store request (sw).
REQ-010 writedata  input  32  store data (rt value).
REQ-011 byteenable  input  4  byte lanes; bit n selects writedata[8n+7:8n].
REQ-012 readdata  output  32  load data, valid only in the DONE cycle.
REQ-013 waitrequest  output  1  high = initiator must hold its request stable.
REQ-014 err  output  1  one-cycle error flag, asserted only in the DONE cycle.

Function
REQ-015 SHALL implement states IDLE, BUSY and DONE; reset state SHALL be IDLE.
REQ-016 In IDLE, waitrequest SHALL equal (read | write), combinationally.
REQ-017 In IDLE with read or write high, SHALL latch address, writedata, byteenable and request type; SHALL load the counter with WAIT_CYCLES; SHALL enter BUSY, or DONE if WAIT_CYCLES = 0.
REQ-018 In BUSY, waitrequest SHALL be 1 and the counter SHALL decrement once per cycle.
REQ-019 BUSY SHALL go to DONE on the edge where the counter reads 0.
REQ-020 On entry to DONE, a valid write SHALL update only the enabled byte lanes of word (address - BASE_ADDR) >> 2.
REQ-021 On entry to DONE, a valid read SHALL register that full word into readdata.
REQ-022 In DONE, waitrequest SHALL be 0 for exactly one cycle; that cycle completes the transfer; next state SHALL be IDLE.
REQ-023 Latency from first request cycle to completion cycle SHALL be WAIT_CYCLES + 2 cycles; no new request SHALL be accepted in DONE.
REQ-024 A request is invalid if any of the following holds: address[1:0] != 0; address < BASE_ADDR; word index >= DEPTH_WORDS; read and write both high.
REQ-025 An invalid request SHALL complete normally in timing, assert err in DONE, suppress any memory write, and return readdata = 0.
REQ-026 If read and write are both low during BUSY (initiator abort), SHALL return to IDLE next cycle with no memory write, err = 0, readdata unchanged.
REQ-027 Changes to address or data during BUSY SHALL be ignored; the latched values are used.
REQ-028 readdata SHALL hold its last value outside DONE.
REQ-029 byteenable = 4'b0000 on a write SHALL complete with no memory change and err = 0.
REQ-030 Memory SHALL be synchronous single-port; its contents are undefined after power-up.

Reset
REQ-031 Reset SHALL force state IDLE, counter 0, readdata 0 and err 0; waitrequest SHALL then follow REQ-016.
REQ-032 Reset asserted in BUSY or DONE SHALL discard the pending access; a store not yet committed SHALL NOT reach memory.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 After reset release, the first request SHALL be accepted on the first rising clk edge.

Verification
REQ-035 Store then load: write 0xDEADBEEF to 0x1000 with be = 4'hF, then read 0x1000 -> readdata 0xDEADBEEF; waitrequest high 3 cycles, low in cycle 4; err 0.
REQ-036 Byte lanes: word at 0x1004 = 0x11223344; write 0xAABBCCDD with be = 4'b0101 -> subsequent read returns 0x11BB33DD.
REQ-037 Errors: read 0x1002 -> err 1, readdata 0; write to 0x0FFC -> err 1, memory unchanged; read and write together -> err 1.
REQ-038 Abort and reset: drop write in the first BUSY cycle -> IDLE next cycle, word unchanged; assert reset in BUSY of a write -> readdata 0, word unchanged.
REQ-039 WAIT_CYCLES = 0: read of a valid word -> waitrequest high 1 cycle, DONE in cycle 2; back-to-back reads each take 2 cycles.
REQ-040 Boundary: DEPTH_WORDS = 1024, read 0x1FFC succeeds; read 0x2000 -> err 1.
